// File: rtl/div_bcd_ctrl_pkg.sv
// div_bcd_ctrl_pkg
//   Shared definitions for the binary-to-BCD formatter: controller state
//   encoding, the fixed divisor, and a helper that sizes the digit store
//   for a given operand width.
package div_bcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    FIN
  } state_e;

  localparam int DIV_TEN = 10;

  // Smallest digit count d with 10^d > 2^len (valid for len up to ~60).
  function automatic int min_digits(input int len);
    longint lim;
    longint p;
    int     d;
    lim = longint'(1) << len;
    p   = 1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p <= lim) begin
        p = p * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/div_watchdog.sv
// div_watchdog
//   Loadable down-counter used to bound the wait for a divider result.
//   Only instantiated when BCD_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : preload the counter with TIMEOUT-1
//   en        : count down by one (saturates at zero)
//   expired   : counter has reached zero
module div_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with TIMEOUT-1 on entry, so zero is seen in the TIMEOUT-th
  // cycle spent waiting.
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/div_bcd_ctrl.sv
// div_bcd_ctrl
//   Binary-to-BCD formatter driving an external sequential divider with
//   divisor 10. Each remainder becomes one decimal digit, least significant
//   first; conversion stops once the quotient reaches zero or the digit
//   store is full.
//   Optional feature macro: BCD_TIMEOUT_EN (watchdog on the divider wait;
//   without it ERR is tied low and no counter exists).
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   START, VAL      : conversion request and value (sampled in IDLE only)
//   BUSY, DONE      : not-idle flag, one-cycle result-valid pulse
//   BCD, NDIG       : packed digits (digit k at [4k+3:4k]), significant count
//   ERR             : watchdog abort flag
//   DIV_START/A/B   : divider request, dividend, divisor (always 10)
//   DIV_DONE/Q/R    : divider result valid, quotient, remainder
module div_bcd_ctrl
  import div_bcd_ctrl_pkg::*;
#(
  parameter int LEN     = 16,
  parameter int DIGITS  = 5,
  parameter int TIMEOUT = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [LEN-1:0]               VAL,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [4*DIGITS-1:0]          BCD,
  output logic [$clog2(DIGITS+1)-1:0]  NDIG,
  output logic                         ERR,
  output logic                         DIV_START,
  output logic [LEN-1:0]               DIV_A,
  output logic [LEN-1:0]               DIV_B,
  input  logic                         DIV_DONE,
  input  logic [LEN-1:0]               DIV_Q,
  input  logic [LEN-1:0]               DIV_R
);

  localparam int NW = $clog2(DIGITS + 1);

  state_e              state_q, state_d;
  logic [LEN-1:0]      cur_q,   cur_d;
  logic [4*DIGITS-1:0] bcd_q,   bcd_d;
  logic [NW-1:0]       k_q,     k_d;
  logic [NW-1:0]       ndig_q,  ndig_d;

  // Only the low nibble of the remainder can be a decimal digit.
  logic unused_bits;
  assign unused_bits = ^{DIV_R[LEN-1:4], TIMEOUT[0]};

`ifdef BCD_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_expired;

  // Preload while in SETTLE so the count starts fresh on entry to WAIT.
  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .rst     (RST),
    .load    (state_q == SETTLE),
    .en      (state_q == WAIT),
    .expired (wd_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bcd_d   = bcd_q;
    k_d     = k_q;
    ndig_d  = ndig_q;
`ifdef BCD_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          cur_d   = VAL;
          bcd_d   = '0;
          k_d     = '0;
          ndig_d  = '0;
`ifdef BCD_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      // The divider's DONE from the previous digit may still be high here.
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (DIV_DONE) begin
          bcd_d[4*k_q +: 4] = DIV_R[3:0];
          cur_d             = DIV_Q;
          k_d               = k_q + 1'b1;
          if ((DIV_Q == '0) || (k_q == NW'(DIGITS - 1))) begin
            ndig_d  = k_q + 1'b1;
            state_d = FIN;
          end else begin
            state_d = ISSUE;
          end
        end
`ifdef BCD_TIMEOUT_EN
        else if (wd_expired) begin
          ndig_d  = k_q;
          err_d   = 1'b1;
          state_d = FIN;
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cur_q   <= '0;
      bcd_q   <= '0;
      k_q     <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bcd_q   <= bcd_d;
      k_q     <= k_d;
      ndig_q  <= ndig_d;
    end
  end

`ifdef BCD_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign BUSY      = (state_q != IDLE);
  assign DONE      = (state_q == FIN);
  assign DIV_START = (state_q == ISSUE);
  assign DIV_A     = cur_q;
  assign DIV_B     = LEN'(DIV_TEN);
  assign BCD       = bcd_q;
  assign NDIG      = ndig_q;

endmodule

// File: tb/tb_div_bcd_ctrl.sv
// tb_div_bcd_ctrl
//   Directed, table-driven bench for div_bcd_ctrl with a behavioural divider
//   (result valid 4 cycles after the strobe edge, DONE sticky until one
//   cycle after the next strobe) plus hand-written corner sequences.
module tb_div_bcd_ctrl;

  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] VAL;
  logic        BUSY, DONE, ERR, DIV_START;
  logic [19:0] BCD;
  logic [2:0]  NDIG;
  logic [15:0] DIV_A, DIV_B;
  logic        DIV_DONE;
  logic [15:0] DIV_Q, DIV_R;

  always #5 CLK = ~CLK;

  div_bcd_ctrl #(.LEN(16), .DIGITS(5), .TIMEOUT(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .VAL(VAL),
    .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .NDIG(NDIG), .ERR(ERR),
    .DIV_START(DIV_START), .DIV_A(DIV_A), .DIV_B(DIV_B),
    .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q), .DIV_R(DIV_R)
  );

  // Divider model
  logic [15:0] mq = '0, mr = '0;
  logic        mdone = 1'b0, clr = 1'b0;
  int          cnt = 0;
  bit          stall = 1'b0;

  always @(posedge CLK) begin
    if (DIV_START) begin
      mq  <= DIV_A / 16'd10;
      mr  <= DIV_A % 16'd10;
      cnt <= D - 1;
      clr <= 1'b1;
    end else begin
      if (clr) begin
        mdone <= 1'b0;
        clr   <= 1'b0;
      end
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && !stall) mdone <= 1'b1;
      end
    end
  end

  assign DIV_DONE = mdone;
  assign DIV_Q    = mq;
  assign DIV_R    = mr;

  // Strobe monitor
  int start_total = 0;
  int b_bad = 0;
  int consec_bad = 0;
  bit prev_st = 1'b0;

  always @(posedge CLK) begin
    if (DIV_START) begin
      start_total++;
      if (DIV_B !== 16'd10) b_bad++;
      if (prev_st) consec_bad++;
    end
    prev_st = DIV_START;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one conversion starting in the current (idle) cycle; returns in
  // the cycle after DONE so the next call starts back-to-back.
  task automatic convert(input logic [15:0] v, input bit hold,
                         output logic [19:0] o_bcd, output logic [2:0] o_ndig,
                         output int o_cyc, output int o_starts,
                         output bit o_done, output bit o_pulse_ok,
                         output logic o_err);
    int s0;
    s0    = start_total;
    START = 1'b1;
    VAL   = v;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    o_cyc = 1;
    while (!DONE && o_cyc < 200) begin
      @(posedge CLK); #1;
      o_cyc++;
      if (hold) VAL = v ^ 16'(o_cyc * 37);
    end
    o_done = DONE;
    START  = 1'b0;
    o_bcd  = BCD;
    o_ndig = NDIG;
    o_err  = ERR;
    @(posedge CLK); #1;
    o_pulse_ok = !DONE && !BUSY && (BCD == o_bcd) && (NDIG == o_ndig);
    o_starts   = start_total - s0;
  endtask

  typedef struct {
    logic [15:0] val;
    logic [19:0] bcd;
    logic [2:0]  ndig;
    int          starts;
    int          cyc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [19:0] g_bcd;
    logic [2:0]  g_ndig;
    logic        g_err;
    int          g_cyc, g_starts, s0, busy_seen;
    bit          g_done, g_pulse;

    vecs[0] = '{16'd12345, 20'h12345, 3'd5, 5, 26};
    vecs[1] = '{16'd0,     20'h00000, 3'd1, 1, 6};
    vecs[2] = '{16'd100,   20'h00100, 3'd3, 3, 16};
    vecs[3] = '{16'd65535, 20'h65535, 3'd5, 5, 26};

    RST = 1'b1; START = 1'b0; VAL = '0;
    repeat (3) @(posedge CLK);
    #1;
    // RST and START together: reset wins
    START = 1'b1; VAL = 16'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    RST   = 1'b0;
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done_bcd_ndig", {11'd0, DONE, BCD}, 32'd0);
    check("reset_ndig_err", {28'd0, NDIG, ERR}, 32'd0);
    check("reset_divstart_diva", {15'd0, DIV_START, DIV_A}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      convert(vecs[i].val, 1'b0, g_bcd, g_ndig, g_cyc, g_starts, g_done, g_pulse, g_err);
      check($sformatf("vec%0d_done", i), 32'(g_done), 32'd1);
      check($sformatf("vec%0d_bcd", i), 32'(g_bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_ndig", i), 32'(g_ndig), 32'(vecs[i].ndig));
      check($sformatf("vec%0d_starts", i), 32'(g_starts), 32'(vecs[i].starts));
      check($sformatf("vec%0d_cycle", i), 32'(g_cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_pulse_hold", i), 32'(g_pulse), 32'd1);
      check($sformatf("vec%0d_err", i), 32'(g_err), 32'd0);
    end

    // START held high through the whole VAL=7 conversion
    s0 = start_total;
    convert(16'd7, 1'b1, g_bcd, g_ndig, g_cyc, g_starts, g_done, g_pulse, g_err);
    repeat (8) @(posedge CLK);
    #1;
    check("hold_bcd", 32'(g_bcd), 32'h00007);
    check("hold_ndig", 32'(g_ndig), 32'd1);
    check("hold_cycle", 32'(g_cyc), 32'd6);
    check("hold_single_strobe", 32'(start_total - s0), 32'd1);
    check("hold_idle_after", 32'(BUSY), 32'd0);

    // Reset in the cycle after the second strobe of VAL=9876
    s0 = start_total;
    START = 1'b1; VAL = 16'd9876;
    @(posedge CLK); #1;
    START = 1'b0;
    g_cyc = 0;
    while ((start_total - s0) < 2 && g_cyc < 100) begin
      @(posedge CLK); #1;
      g_cyc++;
    end
    check("rst_seq_second_strobe", 32'(start_total - s0), 32'd2);
    check("rst_seq_partial_bcd", 32'(BCD), 32'h00006);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_mid_busy_done", {30'd0, BUSY, DONE}, 32'd0);
    check("rst_mid_bcd", 32'(BCD), 32'd0);
    check("rst_mid_ndig_err", {28'd0, NDIG, ERR}, 32'd0);
    check("rst_mid_divstart_diva", {15'd0, DIV_START, DIV_A}, 32'd0);
    s0 = start_total;
    busy_seen = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (BUSY || DONE) busy_seen++;
    end
    check("rst_mid_no_strobe", 32'(start_total - s0), 32'd0);
    check("rst_mid_late_done_ignored", 32'(busy_seen), 32'd0);
    convert(16'd42, 1'b0, g_bcd, g_ndig, g_cyc, g_starts, g_done, g_pulse, g_err);
    check("after_rst_bcd", 32'(g_bcd), 32'h00042);
    check("after_rst_ndig", 32'(g_ndig), 32'd2);
    check("after_rst_cycle", 32'(g_cyc), 32'd11);
    check("after_rst_starts", 32'(g_starts), 32'd2);

`ifdef BCD_TIMEOUT_EN
    // Divider never answers: WAIT entered after edge 2, FIN after 2+32
    stall = 1'b1;
    convert(16'd5, 1'b0, g_bcd, g_ndig, g_cyc, g_starts, g_done, g_pulse, g_err);
    stall = 1'b0;
    check("timeout_done", 32'(g_done), 32'd1);
    check("timeout_err", 32'(g_err), 32'd1);
    check("timeout_cycle", 32'(g_cyc), 32'd35);
    check("timeout_ndig", 32'(g_ndig), 32'd0);
    check("timeout_bcd", 32'(g_bcd), 32'd0);
    convert(16'd58, 1'b0, g_bcd, g_ndig, g_cyc, g_starts, g_done, g_pulse, g_err);
    check("timeout_err_cleared", 32'(g_err), 32'd0);
    check("timeout_recover_bcd", 32'(g_bcd), 32'h00058);
`endif

    check("div_b_always_10", 32'(b_bad), 32'd0);
    check("no_back_to_back_strobe", 32'(consec_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
